// File: rtl/mips_data_bus.sv
// rtl/mips_data_bus.sv - data RAM plus memory-mapped LED, timer and UART TX for the MIPS core
// Loads are combinational from AluOut; all state updates on the rising edge of CLK.
module mips_data_bus #(
    parameter int RAM_AW       = 6,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] AluOut,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] Led,
    output logic        UartTx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CLK_ONE = CW'(1);

    // Word addresses (byte address >> 2) of the I/O registers.
    localparam logic [29:0] A_LED    = 30'h3FFF_C000;
    localparam logic [29:0] A_TCOUNT = 30'h3FFF_C001;
    localparam logic [29:0] A_TCMP   = 30'h3FFF_C002;
    localparam logic [29:0] A_UTXD   = 30'h3FFF_C003;
    localparam logic [29:0] A_STATUS = 30'h3FFF_C004;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    logic [31:0]   r_ram [0:(2**RAM_AW)-1];
    logic [15:0]   r_led;
    logic [31:0]   r_tcount;
    logic [31:0]   r_tcmp;
    logic          r_flag;
    uart_state_t   r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;

    uart_state_t   w_state_nx;
    logic [CW-1:0] w_clk_nx;
    logic [2:0]    w_bit_nx;
    logic [7:0]    w_shift_nx;

    logic [29:0]   w_wa;
    logic          w_wr_ram;
    logic          w_wr_led;
    logic          w_wr_tcount;
    logic          w_wr_tcmp;
    logic          w_wr_utxd;
    logic          w_wr_status;
    logic          w_match;
    logic          w_busy;
    logic          w_bit_end;
    logic          w_unused;

    assign w_wa        = AluOut[31:2];
    assign w_wr_ram    = MemWrite && !AluOut[31];
    assign w_wr_led    = MemWrite && (w_wa == A_LED);
    assign w_wr_tcount = MemWrite && (w_wa == A_TCOUNT);
    assign w_wr_tcmp   = MemWrite && (w_wa == A_TCMP);
    assign w_wr_utxd   = MemWrite && (w_wa == A_UTXD);
    assign w_wr_status = MemWrite && (w_wa == A_STATUS);
    assign w_unused    = ^AluOut[1:0];

    assign w_match   = (r_tcmp != 32'd0) && (r_tcount == r_tcmp) && !w_wr_tcount;
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit_end = (r_clk_cnt == CPB_M1);
    assign Led       = r_led;

    // RAM has no reset; contents are undefined until stored.
    always_ff @(posedge CLK) begin
        if (w_wr_ram) begin
            r_ram[AluOut[RAM_AW+1:2]] <= WriteData;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_led    <= 16'h0000;
            r_tcount <= 32'd0;
            r_tcmp   <= 32'd0;
            r_flag   <= 1'b0;
        end else begin
            if (w_wr_led) begin
                r_led <= WriteData[15:0];
            end
            if (w_wr_tcmp) begin
                r_tcmp <= WriteData;
            end
            if (w_wr_tcount) begin
                r_tcount <= WriteData;
            end else if (w_match) begin
                r_tcount <= 32'd0;
            end else begin
                r_tcount <= r_tcount + 32'd1;
            end
            // Setting the flag beats a same-cycle clear.
            if (w_match) begin
                r_flag <= 1'b1;
            end else if (w_wr_status && WriteData[1]) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_state   <= w_state_nx;
            r_clk_cnt <= w_clk_nx;
            r_bit_cnt <= w_bit_nx;
            r_shift   <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_clk_nx   = r_clk_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_wr_utxd) begin
                    w_state_nx = S_START;
                    w_clk_nx   = '0;
                    w_bit_nx   = 3'd0;
                    w_shift_nx = WriteData[7:0];
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nx = S_DATA;
                    w_clk_nx   = '0;
                    w_bit_nx   = 3'd0;
                end else begin
                    w_clk_nx = r_clk_cnt + CLK_ONE;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_nx   = '0;
                    w_shift_nx = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_bit_nx = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CLK_ONE;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nx = S_IDLE;
                    w_clk_nx   = '0;
                end else begin
                    w_clk_nx = r_clk_cnt + CLK_ONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Line level is decoded from state so Reset drives it high without waiting for a clock.
    always_comb begin
        UartTx = 1'b1;
        case (r_state)
            S_START: UartTx = 1'b0;
            S_DATA:  UartTx = r_shift[0];
            default: UartTx = 1'b1;
        endcase
    end

    always_comb begin
        ReadData = 32'd0;
        if (!AluOut[31]) begin
            ReadData = r_ram[AluOut[RAM_AW+1:2]];
        end else begin
            case (w_wa)
                A_LED:    ReadData = {16'h0000, r_led};
                A_TCOUNT: ReadData = r_tcount;
                A_TCMP:   ReadData = r_tcmp;
                A_STATUS: ReadData = {30'd0, r_flag, w_busy};
                default:  ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_bus.sv
// tb/tb_mips_data_bus.sv - directed self-checking bench for mips_data_bus
module tb_mips_data_bus;

    localparam logic [31:0] LED    = 32'hFFFF_0000;
    localparam logic [31:0] TCOUNT = 32'hFFFF_0004;
    localparam logic [31:0] TCMP   = 32'hFFFF_0008;
    localparam logic [31:0] UTXD   = 32'hFFFF_000C;
    localparam logic [31:0] STATUS = 32'hFFFF_0010;

    logic        CLK;
    logic        Reset;
    logic        MemWrite;
    logic [31:0] AluOut;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] Led;
    logic        UartTx;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] frame;

    mips_data_bus #(.RAM_AW(6), .CLKS_PER_BIT(4)) dut (
        .CLK(CLK), .Reset(Reset), .MemWrite(MemWrite), .AluOut(AluOut),
        .WriteData(WriteData), .ReadData(ReadData), .Led(Led), .UartTx(UartTx)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        AluOut = addr;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        AluOut    = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; MemWrite = 1'b0; AluOut = 32'd0; WriteData = 32'd0;
        repeat (2) tick();
        check("rst_led", {16'h0, Led}, 32'h0);
        check("rst_tx", {31'h0, UartTx}, 32'h1);
        rd("rst_status", STATUS, 32'h0);
        rd("rst_tcount", TCOUNT, 32'h0);
        Reset = 1'b0;
        repeat (5) tick();
        rd("tcount_5", TCOUNT, 32'd5);

        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_10_next", 32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h1234_5678);
        rd("ram_14", 32'h0000_0014, 32'h1234_5678);
        rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);

        wr(LED, 32'hABCD_1234);
        check("led_out", {16'h0, Led}, 32'h0000_1234);
        rd("led_rd", LED, 32'h0000_1234);
        wr(32'hFFFF_0020, 32'h5555_AAAA);
        rd("unmapped_rd", 32'hFFFF_0020, 32'h0);
        check("led_kept", {16'h0, Led}, 32'h0000_1234);
        rd("utxd_rd", UTXD, 32'h0);

        wr(TCMP, 32'd3);
        rd("tcmp_rd", TCMP, 32'd3);
        wr(TCOUNT, 32'd0);
        rd("tc_load0", TCOUNT, 32'd0);
        repeat (3) tick();
        rd("tc_at3", TCOUNT, 32'd3);
        rd("flag_pre", STATUS, 32'h0);
        tick();
        rd("tc_wrap", TCOUNT, 32'd0);
        rd("flag_set", STATUS, 32'h2);
        wr(STATUS, 32'h2);
        rd("flag_clr", STATUS, 32'h0);
        rd("tc_after_clr", TCOUNT, 32'd1);
        repeat (2) tick();
        wr(TCOUNT, 32'd100);
        rd("tc_wr_wins", TCOUNT, 32'd100);
        rd("flag_wr_nomatch", STATUS, 32'h0);
        wr(TCOUNT, 32'd2);
        tick();
        wr(STATUS, 32'h2);
        rd("flag_set_wins", STATUS, 32'h2);
        rd("tc_wrap2", TCOUNT, 32'd0);
        wr(STATUS, 32'h2);
        wr(TCMP, 32'd0);
        wr(TCOUNT, 32'd2);
        repeat (3) tick();
        rd("tc_disabled", TCOUNT, 32'd5);
        rd("flag_disabled", STATUS, 32'h0);

        // 0x55 framed: start 0, data LSB first, stop 1
        frame = {1'b1, 8'h55, 1'b0};
        wr(UTXD, 32'h0000_0055);
        rd("busy_k", STATUS, 32'h1);
        for (int c = 0; c < 40; c++) begin
            check($sformatf("tx55_c%0d", c), {31'h0, UartTx}, {31'h0, frame[c/4]});
            if (c == 10) wr(UTXD, 32'h0000_00FF);
            else if (c == 39) wr(UTXD, 32'h0000_0000);
            else tick();
        end
        rd("busy_end", STATUS, 32'h0);
        check("tx_idle_end", {31'h0, UartTx}, 32'h1);
        repeat (6) tick();
        check("tx_drop_edge", {31'h0, UartTx}, 32'h1);
        rd("busy_drop_edge", STATUS, 32'h0);

        wr(UTXD, 32'h0000_0000);
        repeat (13) tick();
        check("tx_mid_c13", {31'h0, UartTx}, 32'h0);
        Reset = 1'b1;
        #1;
        check("tx_async_rst", {31'h0, UartTx}, 32'h1);
        rd("busy_async_rst", STATUS, 32'h0);
        check("led_rst2", {16'h0, Led}, 32'h0);
        tick();
        Reset = 1'b0;
        rd("ram_survives_rst", 32'h0000_0010, 32'hDEAD_BEEF);

        frame = {1'b1, 8'hA3, 1'b0};
        wr(UTXD, 32'h0000_00A3);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("txA3_b%0d", i), {31'h0, UartTx}, {31'h0, frame[i]});
            repeat (4) tick();
        end
        rd("busy_A3_end", STATUS, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_data_bus.md
Name: mips_data_bus

Overview:
- Data-side memory and I/O subsystem directly downstream of the single-cycle MIPS core.
- Consumes the core's store strobe, ALU-computed address and store data; returns load data combinationally in the same cycle.
- Contains the data RAM plus a memory-mapped LED register, a free-running timer with compare flag, and an 8N1 UART transmitter.

Parameters:
- RAM_AW, 6, word-address width of data RAM (2**RAM_AW 32-bit words).
- CLKS_PER_BIT, 16, clock cycles per UART bit period (>=2).

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store strobe from core, sampled at rising edge of CLK.
- AluOut  input  32  byte address from core.
- WriteData  input  32  store data from core.
- ReadData  output  32  load data, combinational function of AluOut and current state.
- Led  output  16  LED register contents.
- UartTx  output  1  serial transmit line, idle high.

Behaviour:
- Address decode (AluOut[1:0] ignored, word accesses only):
  - AluOut[31]=0: RAM, index AluOut[RAM_AW+1:2]. Upper bits alias.
  - 0xFFFF0000 LED: R/W. Bits [15:0] used; reads zero-extended.
  - 0xFFFF0004 TCOUNT: R/W. A write loads the count.
  - 0xFFFF0008 TCMP: R/W.
  - 0xFFFF000C UTXD: W-only, reads 0. A write starts a frame with WriteData[7:0] if the UART is idle; it is dropped if busy.
  - 0xFFFF0010 STATUS: R. Bit0 = uart_busy, bit1 = timer_flag, other bits 0. A write with WriteData[1]=1 clears timer_flag.
  - Any other address with AluOut[31]=1: reads 0, writes ignored.
- RAM: asynchronous read, synchronous write when MemWrite=1. Not cleared by Reset (contents X until written). A store followed by a load to the same address in the next cycle returns the new data.
- Reset values:
  - Led=0, UartTx=1, TCOUNT=0, TCMP=0, timer_flag=0, uart_busy=0.
  - UART state IDLE; bit and clock counters 0.
  - Assertion mid-frame forces UartTx=1 immediately.
- Timer:
  - TCOUNT increments by 1 every cycle, 32-bit wrap.
  - If TCMP!=0 and TCOUNT==TCMP: the next TCOUNT is 0 and timer_flag is set (sticky).
  - A CPU write to TCOUNT takes precedence over increment and match; no flag set in that cycle.
  - Flag set and clear in the same cycle: set wins.
  - TCMP=0 disables matching.
- UART TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Accepted write at edge k: busy=1 and UartTx=0 from edge k (START).
  - Each state holds CLKS_PER_BIT cycles.
  - DATA shifts 8 bits LSB first.
  - STOP drives 1.
  - Return to IDLE and busy=0 at edge k+10*CLKS_PER_BIT.
  - A write to UTXD on that same edge is dropped (busy still 1 when sampled).
  - Data byte latched at acceptance; later UTXD writes do not disturb the frame.
- ReadData has no internal pipeline: latency 0 cycles. Writes are visible on the cycle after the edge.

Test Plan:
- Reset asserted -> Led=0, UartTx=1, ReadData@0xFFFF0010=0, ReadData@0xFFFF0004=0. Release, wait 5 cycles -> TCOUNT reads 5.
- RAM: store 0xDEADBEEF @0x00000010, store 0x12345678 @0x00000014 -> loads return the values. Load @0x00000010+(4<<RAM_AW) returns 0xDEADBEEF (alias).
- LED: store 0xABCD1234 @0xFFFF0000 -> Led=0x1234, readback 0x00001234. Store to 0xFFFF0020 -> ignored, reads 0.
- Timer: TCMP=3, TCOUNT=0 -> flag set when count hits 3, count becomes 0, STATUS=0x2. Write STATUS 0x2 -> flag clears. Write TCOUNT same cycle as match -> no flag.
- UART: CLKS_PER_BIT=4, write 0x55 to UTXD -> UartTx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. Busy for 40 cycles. Second write of 0xFF during frame is ignored.
- Reset asserted mid-frame (cycle 13) -> UartTx=1 asynchronously, busy=0. A new write after release transmits correctly.
